l2_cache_control: RTL and testbench
===================================

# l2_cache_control

Control FSM for the 4-way, 32-set, 128-bit-line L2 cache datapath. It sits between the L1-side request port (`cache_read`/`cache_write`/`cache_resp`) and the physical memory port (`mem_read`/`mem_write`/`mem_resp`). Each cycle it drives the datapath's array load strobes, the R_W mux select, the dirty-bit value and the LRU update. It also keeps saturating performance counters.

## Interface
- `CNT_WIDTH`, 16, width of each performance counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cache_read`, `cache_write` in 1 each: L1 request. Held until `cache_resp`; never both high.
- `cache_resp` out 1: request complete this cycle.
- `way1_hit`..`way4_hit` in 1 each: per-way tag match && valid.
- `read_hit`, `write_hit` in 1 each: any hit qualified by `cache_read` / `cache_write`.
- `LRU_out` in 8: LRU stack for the set. `[1:0]` is the victim way (0..3 = way1..way4).
- `dirty_out` in 1: dirty bit of the victim way.
- `R_W` out 1:
  - 0: `data_in` = `mem_rdata`, `mem_address` = request address.
  - 1: `data_in` = `cache_wdata`, `mem_address` = victim writeback address.
- `load_data_1`..`load_data_4` out 1 each: write data/tag/valid of that way.
- `dirty_bit` out 1: value written by `load_dirty_*`.
- `load_dirty_1`..`load_dirty_4` out 1 each: write dirty bit of that way.
- `load_LRU` out 1: commit the updated LRU stack.
- `LRU_way` out 2: way being touched (0..3).
- `mem_read`, `mem_write` out 1 each: memory request, held until `mem_resp`.
- `mem_resp` in 1: memory transaction done.
- `busy` out 1: FSM not in IDLE.
- `req_count`, `miss_count`, `wb_count` out CNT_WIDTH each: completed requests, misses, writebacks.

## Operation
- States: IDLE, WRITEBACK, ALLOCATE.
- Hit-way encoding: way1→0, way2→1, way3→2, way4→3. If more than one hit is asserted (illegal), the lowest-numbered way wins.
- Victim way is v = `LRU_out[1:0]`.
- IDLE, no request: all strobes 0, `R_W`=0, `LRU_way`=0.
- IDLE, `read_hit`:
  - `cache_resp`=1, `load_LRU`=1, `LRU_way`=hit way.
  - Stay in IDLE; `req_count`++.
- IDLE, `write_hit`:
  - `R_W`=1; `load_data_h`=1 and `load_dirty_h`=1 for hit way h; `dirty_bit`=1.
  - `load_LRU`=1, `LRU_way`=h, `cache_resp`=1.
  - Stay in IDLE; `req_count`++.
- IDLE, request without hit: `miss_count`++. Next state is WRITEBACK if `dirty_out`=1, else ALLOCATE. No strobes this cycle.
- WRITEBACK:
  - `R_W`=1, `mem_write`=1.
  - On `mem_resp`: `wb_count`++, go to ALLOCATE.
- ALLOCATE:
  - `R_W`=0, `mem_read`=1.
  - On `mem_resp`: `load_data_v`=1, `load_dirty_v`=1, `dirty_bit`=0, go to IDLE.
- After ALLOCATE, IDLE re-evaluates the still-held request. It now hits and completes through the normal hit path, which is the only place the LRU is updated and the only place `req_count` increments.
- `load_LRU` is never asserted outside IDLE.
- Only one `load_data_*` and one `load_dirty_*` may be high in any cycle.
- Counters saturate at all-ones; they do not wrap.
- If the request drops during WRITEBACK or ALLOCATE, the memory transaction still completes and the FSM returns to IDLE with no `cache_resp`.
- `mem_resp` outside WRITEBACK/ALLOCATE is ignored.

## Timing
- Reset (async, while `rst_n`=0):
  - State goes to IDLE.
  - All outputs 0: `cache_resp`, `R_W`, every load strobe, `dirty_bit`, `LRU_way`, `mem_read`, `mem_write`, `busy`.
  - All counters 0.
- Reset mid-transaction abandons it immediately and deasserts `mem_read`/`mem_write` the same cycle.
- All outputs except the counters and `busy` are combinational on state and inputs (Mealy).
- The array and LRU writes commit at the rising edge that ends the cycle in which the strobe is high.
- Hit latency: `cache_resp` in the same cycle the request is seen in IDLE.
- Clean miss: 1 cycle (IDLE) + N ALLOCATE cycles (including the `mem_resp` cycle) + 1 cycle (IDLE hit).
- Dirty miss: adds M WRITEBACK cycles.
- `mem_read`/`mem_write` are held constant until the `mem_resp` cycle and drop the following cycle. They are never both high.

## Test plan
- Reset, then cold read to address 0x1230 (set 0x03):
  - Cycle 0: miss, `miss_count`=1.
  - Then ALLOCATE with `mem_read`=1 and `R_W`=0.
  - On `mem_resp`: `load_data_1`=1 (LRU victim 0), `load_dirty_1`=1, `dirty_bit`=0.
  - Next cycle: `cache_resp`=1, `load_LRU`=1, `LRU_way`=0, `req_count`=1.
- Write hit in way3:
  - Same cycle: `R_W`=1, `load_data_3`=1, `load_dirty_3`=1, `dirty_bit`=1, `LRU_way`=2, `cache_resp`=1.
  - `busy` stays 0.
- Miss with `LRU_out[1:0]`=2 and `dirty_out`=1:
  - WRITEBACK: `mem_write`=1, `R_W`=1.
  - After `mem_resp`: `wb_count`=1, then ALLOCATE loads way3.
  - Then a hit response follows.
- Assert `rst_n`=0 midway through ALLOCATE: `mem_read` drops immediately, state returns to IDLE, counters read 0, no `load_*` pulse occurs.
- Preload `miss_count` to 0xFFFF (force or 65535 misses), then one more miss: the count stays 0xFFFF.
- Drop `cache_read` during ALLOCATE:
  - The fill still completes with `load_data_v` on `mem_resp`.
  - The FSM returns to IDLE with `cache_resp`=0 and `req_count` unchanged.

Source files
------------

// File: rtl/l2_cache_control.sv
// Control FSM for the 4-way L2 cache datapath: sequences hits, dirty-victim
// writebacks and line fills, and keeps saturating request/miss/writeback counters.
module l2_cache_control #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cache_read,
    input  logic                 cache_write,
    output logic                 cache_resp,
    input  logic                 way1_hit,
    input  logic                 way2_hit,
    input  logic                 way3_hit,
    input  logic                 way4_hit,
    input  logic                 read_hit,
    input  logic                 write_hit,
    input  logic [7:0]           LRU_out,
    input  logic                 dirty_out,
    output logic                 R_W,
    output logic                 load_data_1,
    output logic                 load_data_2,
    output logic                 load_data_3,
    output logic                 load_data_4,
    output logic                 dirty_bit,
    output logic                 load_dirty_1,
    output logic                 load_dirty_2,
    output logic                 load_dirty_3,
    output logic                 load_dirty_4,
    output logic                 load_LRU,
    output logic [1:0]           LRU_way,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_resp,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] req_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] req_count_q, req_count_d;
    logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;
    logic [CNT_WIDTH-1:0] wb_count_q, wb_count_d;

    logic [1:0] hit_way;
    logic [1:0] victim;
    logic [3:0] load_data;
    logic [3:0] load_dirty;
    logic       lru_unused;

    assign victim     = LRU_out[1:0];
    assign lru_unused = ^LRU_out[7:2];

    // Illegal multi-hit resolves to the lowest-numbered way.
    always_comb begin
        hit_way = 2'd0;
        if (way1_hit)      hit_way = 2'd0;
        else if (way2_hit) hit_way = 2'd1;
        else if (way3_hit) hit_way = 2'd2;
        else if (way4_hit) hit_way = 2'd3;
    end

    always_comb begin
        state_d      = state_q;
        req_count_d  = req_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        cache_resp   = 1'b0;
        R_W          = 1'b0;
        load_data    = '0;
        load_dirty   = '0;
        dirty_bit    = 1'b0;
        load_LRU     = 1'b0;
        LRU_way      = 2'd0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;

        // Mealy outputs are gated so every strobe reads 0 while reset is held.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (read_hit) begin
                        cache_resp = 1'b1;
                        load_LRU   = 1'b1;
                        LRU_way    = hit_way;
                        if (req_count_q != '1) req_count_d = req_count_q + 1'b1;
                    end else if (write_hit) begin
                        R_W        = 1'b1;
                        load_data  = 4'b0001 << hit_way;
                        load_dirty = 4'b0001 << hit_way;
                        dirty_bit  = 1'b1;
                        load_LRU   = 1'b1;
                        LRU_way    = hit_way;
                        cache_resp = 1'b1;
                        if (req_count_q != '1) req_count_d = req_count_q + 1'b1;
                    end else if (cache_read || cache_write) begin
                        if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
                        state_d = dirty_out ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    R_W       = 1'b1;
                    mem_write = 1'b1;
                    if (mem_resp) begin
                        if (wb_count_q != '1) wb_count_d = wb_count_q + 1'b1;
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_data  = 4'b0001 << victim;
                        load_dirty = 4'b0001 << victim;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_count_q  <= req_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign load_data_1  = load_data[0];
    assign load_data_2  = load_data[1];
    assign load_data_3  = load_data[2];
    assign load_data_4  = load_data[3];
    assign load_dirty_1 = load_dirty[0];
    assign load_dirty_2 = load_dirty[1];
    assign load_dirty_3 = load_dirty[2];
    assign load_dirty_4 = load_dirty[3];
    assign busy         = (state_q != IDLE);
    assign req_count    = req_count_q;
    assign miss_count   = miss_count_q;
    assign wb_count     = wb_count_q;

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control: hits, clean/dirty misses, reset abort,
// dropped requests and counter saturation (via a narrow-counter second instance).
module tb_l2_cache_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_read, cache_write;
    logic        way1_hit, way2_hit, way3_hit, way4_hit;
    logic        read_hit, write_hit;
    logic [7:0]  LRU_out;
    logic        dirty_out;
    logic        mem_resp;

    logic        cache_resp, R_W, dirty_bit, load_LRU, mem_read, mem_write, busy;
    logic [3:0]  ld, ldd;
    logic [1:0]  LRU_way;
    logic [15:0] req_count, miss_count, wb_count;

    logic        s_cache_resp, s_R_W, s_dirty_bit, s_load_LRU, s_mem_read, s_mem_write, s_busy;
    logic [3:0]  s_ld, s_ldd;
    logic [1:0]  s_LRU_way;
    logic [1:0]  s_req_count, s_miss_count, s_wb_count;

    // {cache_resp, R_W, load_data[4:1], load_dirty[4:1], dirty_bit, load_LRU, mem_read, mem_write}
    logic [13:0] strobes;
    logic [47:0] counters;
    assign strobes  = {cache_resp, R_W, ld, ldd, dirty_bit, load_LRU, mem_read, mem_write};
    assign counters = {req_count, miss_count, wb_count};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_cache_control #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cache_read(cache_read), .cache_write(cache_write), .cache_resp(cache_resp),
        .way1_hit(way1_hit), .way2_hit(way2_hit), .way3_hit(way3_hit), .way4_hit(way4_hit),
        .read_hit(read_hit), .write_hit(write_hit), .LRU_out(LRU_out), .dirty_out(dirty_out),
        .R_W(R_W),
        .load_data_1(ld[0]), .load_data_2(ld[1]), .load_data_3(ld[2]), .load_data_4(ld[3]),
        .dirty_bit(dirty_bit),
        .load_dirty_1(ldd[0]), .load_dirty_2(ldd[1]), .load_dirty_3(ldd[2]), .load_dirty_4(ldd[3]),
        .load_LRU(load_LRU), .LRU_way(LRU_way),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp), .busy(busy),
        .req_count(req_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    l2_cache_control #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .cache_read(cache_read), .cache_write(cache_write), .cache_resp(s_cache_resp),
        .way1_hit(way1_hit), .way2_hit(way2_hit), .way3_hit(way3_hit), .way4_hit(way4_hit),
        .read_hit(read_hit), .write_hit(write_hit), .LRU_out(LRU_out), .dirty_out(dirty_out),
        .R_W(s_R_W),
        .load_data_1(s_ld[0]), .load_data_2(s_ld[1]), .load_data_3(s_ld[2]), .load_data_4(s_ld[3]),
        .dirty_bit(s_dirty_bit),
        .load_dirty_1(s_ldd[0]), .load_dirty_2(s_ldd[1]), .load_dirty_3(s_ldd[2]), .load_dirty_4(s_ldd[3]),
        .load_LRU(s_load_LRU), .LRU_way(s_LRU_way),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_resp(mem_resp), .busy(s_busy),
        .req_count(s_req_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        cache_read = 1'b0; cache_write = 1'b0;
        way1_hit = 1'b0; way2_hit = 1'b0; way3_hit = 1'b0; way4_hit = 1'b0;
        read_hit = 1'b0; write_hit = 1'b0;
        LRU_out = 8'h00; dirty_out = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        cache_read = 1'b1; way1_hit = 1'b1; read_hit = 1'b1; mem_resp = 1'b1;
        #3;
        checks++;
        if (strobes !== 14'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=%b", strobes, 14'b0);
        end
        checks++;
        if ({busy, LRU_way} !== 3'b000) begin
            failures++; $display("FAIL reset_busy_lruway got=%b exp=%b", {busy, LRU_way}, 3'b000);
        end
        checks++;
        if (counters !== 48'h0) begin
            failures++; $display("FAIL reset_counters got=%h exp=%h", counters, 48'h0);
        end
        repeat (2) cyc();
        clear_inputs();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_clean_miss;
        // cold read to 0x1230, victim way1, clean
        cache_read = 1'b1; LRU_out = 8'h00; dirty_out = 1'b0;
        @(negedge clk);
        checks++;
        if ({strobes, busy} !== 15'b0) begin
            failures++; $display("FAIL cm_miss_cycle got=%b exp=%b", {strobes, busy}, 15'b0);
        end
        cyc();
        checks++;
        if ({miss_count, busy} !== {16'd1, 1'b1}) begin
            failures++; $display("FAIL cm_miss_count got=%0d/%b exp=1/1", miss_count, busy);
        end
        @(negedge clk);
        checks++;
        if (strobes !== 14'b0_0_0000_0000_0_0_1_0) begin
            failures++; $display("FAIL cm_alloc_wait got=%b exp=%b", strobes, 14'b0_0_0000_0000_0_0_1_0);
        end
        cyc();
        mem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== 14'b0_0_0001_0001_0_0_1_0) begin
            failures++; $display("FAIL cm_alloc_fill got=%b exp=%b", strobes, 14'b0_0_0001_0001_0_0_1_0);
        end
        cyc();
        mem_resp = 1'b0; way1_hit = 1'b1; read_hit = 1'b1;
        @(negedge clk);
        checks++;
        if ({strobes, LRU_way, busy} !== {14'b1_0_0000_0000_0_1_0_0, 2'd0, 1'b0}) begin
            failures++; $display("FAIL cm_hit got=%b exp=%b", {strobes, LRU_way, busy},
                                 {14'b1_0_0000_0000_0_1_0_0, 2'd0, 1'b0});
        end
        cyc();
        clear_inputs();
        checks++;
        if (counters !== {16'd1, 16'd1, 16'd0}) begin
            failures++; $display("FAIL cm_counters got=%h exp=%h", counters, {16'd1, 16'd1, 16'd0});
        end
    endtask

    task automatic test_write_hit;
        cache_write = 1'b1; way3_hit = 1'b1; write_hit = 1'b1;
        @(negedge clk);
        checks++;
        if ({strobes, LRU_way, busy} !== {14'b1_1_0100_0100_1_1_0_0, 2'd2, 1'b0}) begin
            failures++; $display("FAIL wh_strobes got=%b exp=%b", {strobes, LRU_way, busy},
                                 {14'b1_1_0100_0100_1_1_0_0, 2'd2, 1'b0});
        end
        cyc();
        clear_inputs();
        checks++;
        if ({req_count, busy} !== {16'd2, 1'b0}) begin
            failures++; $display("FAIL wh_req_busy got=%0d/%b exp=2/0", req_count, busy);
        end
    endtask

    task automatic test_hit_priority;
        cache_read = 1'b1; way2_hit = 1'b1; way4_hit = 1'b1; read_hit = 1'b1;
        @(negedge clk);
        checks++;
        if ({cache_resp, LRU_way} !== {1'b1, 2'd1}) begin
            failures++; $display("FAIL prio_way got=%b exp=%b", {cache_resp, LRU_way}, {1'b1, 2'd1});
        end
        cyc();
        clear_inputs();
        // stray mem_resp in IDLE must be ignored
        mem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if ({strobes, busy} !== 15'b0) begin
            failures++; $display("FAIL idle_memresp got=%b exp=%b", {strobes, busy}, 15'b0);
        end
        cyc();
        clear_inputs();
        checks++;
        if ({counters, busy} !== {16'd3, 16'd1, 16'd0, 1'b0}) begin
            failures++; $display("FAIL prio_counters got=%h/%b exp=%h/0", counters, busy,
                                 {16'd3, 16'd1, 16'd0});
        end
    endtask

    task automatic test_dirty_miss;
        cache_read = 1'b1; LRU_out = 8'h02; dirty_out = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== 14'b0) begin
            failures++; $display("FAIL dm_miss_cycle got=%b exp=%b", strobes, 14'b0);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({strobes, busy} !== {14'b0_1_0000_0000_0_0_0_1, 1'b1}) begin
            failures++; $display("FAIL dm_writeback got=%b exp=%b", {strobes, busy},
                                 {14'b0_1_0000_0000_0_0_0_1, 1'b1});
        end
        cyc();
        mem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== 14'b0_1_0000_0000_0_0_0_1) begin
            failures++; $display("FAIL dm_wb_resp got=%b exp=%b", strobes, 14'b0_1_0000_0000_0_0_0_1);
        end
        cyc();
        checks++;
        if ({miss_count, wb_count} !== {16'd2, 16'd1}) begin
            failures++; $display("FAIL dm_counts got=%0d/%0d exp=2/1", miss_count, wb_count);
        end
        @(negedge clk);
        checks++;
        if (strobes !== 14'b0_0_0100_0100_0_0_1_0) begin
            failures++; $display("FAIL dm_fill got=%b exp=%b", strobes, 14'b0_0_0100_0100_0_0_1_0);
        end
        cyc();
        mem_resp = 1'b0; way3_hit = 1'b1; read_hit = 1'b1;
        @(negedge clk);
        checks++;
        if ({strobes, LRU_way} !== {14'b1_0_0000_0000_0_1_0_0, 2'd2}) begin
            failures++; $display("FAIL dm_hit got=%b exp=%b", {strobes, LRU_way},
                                 {14'b1_0_0000_0000_0_1_0_0, 2'd2});
        end
        cyc();
        clear_inputs();
        checks++;
        if (counters !== {16'd4, 16'd2, 16'd1}) begin
            failures++; $display("FAIL dm_counters got=%h exp=%h", counters, {16'd4, 16'd2, 16'd1});
        end
    endtask

    task automatic test_drop_request;
        cache_read = 1'b1; LRU_out = 8'h01;
        cyc();
        cache_read = 1'b0; mem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== 14'b0_0_0010_0010_0_0_1_0) begin
            failures++; $display("FAIL drop_fill got=%b exp=%b", strobes, 14'b0_0_0010_0010_0_0_1_0);
        end
        cyc();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({strobes, busy} !== 15'b0) begin
            failures++; $display("FAIL drop_idle got=%b exp=%b", {strobes, busy}, 15'b0);
        end
        checks++;
        if (counters !== {16'd4, 16'd3, 16'd1}) begin
            failures++; $display("FAIL drop_counters got=%h exp=%h", counters, {16'd4, 16'd3, 16'd1});
        end
        cyc();
    endtask

    task automatic test_reset_mid_alloc;
        cache_read = 1'b1; LRU_out = 8'h00;
        cyc();
        @(negedge clk);
        checks++;
        if ({mem_read, busy} !== 2'b11) begin
            failures++; $display("FAIL rm_in_alloc got=%b exp=%b", {mem_read, busy}, 2'b11);
        end
        cyc();
        #1;
        mem_resp = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({strobes, busy} !== 15'b0) begin
            failures++; $display("FAIL rm_abort got=%b exp=%b", {strobes, busy}, 15'b0);
        end
        checks++;
        if (counters !== 48'h0) begin
            failures++; $display("FAIL rm_counters got=%h exp=%h", counters, 48'h0);
        end
        cyc();
        clear_inputs();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            cache_read = 1'b1; mem_resp = 1'b0;
            cyc();
            mem_resp = 1'b1;
            cyc();
            if (i == 2) begin
                checks++;
                if (s_miss_count !== 2'd3) begin
                    failures++; $display("FAIL sat_reach got=%0d exp=3", s_miss_count);
                end
            end
        end
        clear_inputs();
        cyc();
        checks++;
        if (s_miss_count !== 2'd3) begin
            failures++; $display("FAIL sat_hold got=%0d exp=3", s_miss_count);
        end
        checks++;
        if (miss_count !== 16'd5) begin
            failures++; $display("FAIL sat_wide got=%0d exp=5", miss_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_hit_priority();
        test_dirty_miss();
        test_drop_request();
        test_reset_mid_alloc();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
